// File: rtl/jtkunio_colmix_pkg.sv
// Shared constants and layer priority helper for the Kunio colour mixer.
// Palette bases, bank select bit and the combinational layer priority.
package jtkunio_colmix_pkg;

  localparam logic [7:0] PAL_CHAR_BASE = 8'h00;
  localparam logic [7:0] PAL_OBJ_BASE  = 8'h80;
  localparam logic [7:0] PAL_SCR_BASE  = 8'hC0;
  localparam int         BANK_BIT      = 8;

  typedef enum logic {
    BANK_RG = 1'b0,
    BANK_B  = 1'b1
  } bank_e;

  // A disabled layer counts as transparent; char beats obj beats scroll.
  function automatic logic [7:0] pal_prio(
    input logic [4:0] chr,
    input logic [4:0] obj,
    input logic [5:0] scr,
    input logic [2:0] en
  );
    logic chr_op;
    logic obj_op;
    chr_op = en[0] & (|chr[2:0]);
    obj_op = en[2] & (|obj[2:0]);
    if (chr_op)
      pal_prio = PAL_CHAR_BASE | {3'b000, chr};
    else if (obj_op)
      pal_prio = PAL_OBJ_BASE | {3'b000, obj};
    else if (en[1])
      pal_prio = PAL_SCR_BASE | {2'b00, scr};
    else
      pal_prio = 8'h00;
  endfunction

endpackage

// File: rtl/jtkunio_colmix_if.sv
// CPU palette bus of the colour mixer.
// addr[8] selects bank, wrn active low, din returned one clk later.
interface jtkunio_colmix_if;
  logic [8:0] cpu_addr;
  logic [7:0] cpu_dout;
  logic       cpu_wrn;
  logic       pal_cs;
  logic [7:0] cpu_din;

  modport master (
    output cpu_addr,
    output cpu_dout,
    output cpu_wrn,
    output pal_cs,
    input  cpu_din
  );

  modport slave (
    input  cpu_addr,
    input  cpu_dout,
    input  cpu_wrn,
    input  pal_cs,
    output cpu_din
  );
endinterface

// File: rtl/jtframe_dual_ram.sv
// Dual port RAM: port 0 read/write, port 1 read only, same clock.
// Both reads are registered and return the pre-write contents.
module jtframe_dual_ram #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic [DW-1:0] data0,
  input  logic [AW-1:0] addr0,
  input  logic          we0,
  output logic [DW-1:0] q0,
  input  logic [AW-1:0] addr1,
  output logic [DW-1:0] q1
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we0) mem[addr0] <= data0;
    q0 <= mem[addr0];
    q1 <= mem[addr1];
  end

endmodule

// File: rtl/jtkunio_colmix.sv
// Colour mixer: layer priority, palette lookup, 2-stage pixel pipe.
// Ports: clk/rst, pxl_cen, blanking, CPU bus, layer pixels, RGB out.
module jtkunio_colmix
  import jtkunio_colmix_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       pxl_cen,
  input  logic       LHBL,
  input  logic       LVBL,
  jtkunio_colmix_if.slave cpu,
  input  logic [4:0] char_pxl,
  input  logic [4:0] obj_pxl,
  input  logic [5:0] scr_pxl,
  input  logic [2:0] gfx_en,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       LHBL_dly,
  output logic       LVBL_dly
);

  logic [7:0] idx;
  logic [7:0] pal_idx;
  logic [1:0] blk1;
  logic [7:0] rg_q;
  logic [7:0] b_q;
  logic [7:0] rg_q0;
  logic [7:0] b_q0;
  logic       we;
  logic       we_rg;
  logic       we_b;
  logic       cpu_sel;
  logic       unused_b;

  assign idx = pal_prio(char_pxl, obj_pxl, scr_pxl, gfx_en);

  assign we    = cpu.pal_cs & ~cpu.cpu_wrn;
  assign we_rg = we & (cpu.cpu_addr[BANK_BIT] == BANK_RG);
  assign we_b  = we & (cpu.cpu_addr[BANK_BIT] == BANK_B);

  jtframe_dual_ram #(.AW(8), .DW(8)) u_rg (
    .clk   (clk),
    .data0 (cpu.cpu_dout),
    .addr0 (cpu.cpu_addr[7:0]),
    .we0   (we_rg),
    .q0    (rg_q0),
    .addr1 (pal_idx),
    .q1    (rg_q)
  );

  jtframe_dual_ram #(.AW(8), .DW(8)) u_b (
    .clk   (clk),
    .data0 (cpu.cpu_dout),
    .addr0 (cpu.cpu_addr[7:0]),
    .we0   (we_b),
    .q0    (b_q0),
    .addr1 (pal_idx),
    .q1    (b_q)
  );

  // Read data lags the address by one clk, so the mux must too.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cpu_sel <= 1'b0;
    else     cpu_sel <= cpu.cpu_addr[BANK_BIT];
  end

  assign cpu.cpu_din = cpu_sel ? {4'h0, b_q0[3:0]} : rg_q0;

  // B bank keeps 8 bits but only the low nibble is colour.
  assign unused_b = ^{b_q[7:4], b_q0[7:4]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pal_idx <= 8'h00;
      blk1    <= 2'b00;
    end else if (pxl_cen) begin
      pal_idx <= idx;
      blk1    <= {LHBL, LVBL};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      red      <= 4'h0;
      green    <= 4'h0;
      blue     <= 4'h0;
      LHBL_dly <= 1'b0;
      LVBL_dly <= 1'b0;
    end else if (pxl_cen) begin
      if (blk1 == 2'b11) begin
        {green, red} <= rg_q;
        blue         <= b_q[3:0];
      end else begin
        red   <= 4'h0;
        green <= 4'h0;
        blue  <= 4'h0;
      end
      {LHBL_dly, LVBL_dly} <= blk1;
    end
  end

endmodule
